sd_block_reader: RTL and testbench

SD_BLOCK_READER -- requirements
Module: sd_block_reader

---
 rtl/sd_xfer_pkg.sv | 21 ++
 rtl/crc16_byte.sv | 23 ++
 rtl/sd_block_reader.sv | 196 +++++++++++++++++++
 tb/tb_sd_block_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_xfer_pkg.sv
// Shared types and constants for the SD block-read path: FSM states,
// SPI token bytes, CRC polynomial and default FIFO sizing.
package sd_xfer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TOK_ISSUE,
      TOK_WAIT,
      DAT_ISSUE,
      DAT_WAIT,
      CRC_ISSUE,
      CRC_WAIT,
      FINISH
   } sd_state_e;

   localparam logic [7:0]  TOKEN_START        = 8'hFE;
   localparam logic [7:0]  IDLE_BYTE          = 8'hFF;
   localparam logic [15:0] CRC16_POLY         = 16'h1021;
   localparam int          DEFAULT_FIFO_DEPTH = 16;

endpackage

// File: rtl/crc16_byte.sv
// Combinational CRC16-CCITT update for one byte, bits taken MSB first.
module crc16_byte
   import sd_xfer_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_byte,
   output logic [15:0] crc_out
);

   logic [15:0] c;
   logic        fb;

   always_comb begin
      c  = crc_in;
      fb = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ data_byte[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
      crc_out = c;
   end

endmodule

// File: rtl/sd_block_reader.sv
// Reads one SD data block through a byte-wide SPI shifter: polls for the start
// token, streams data bytes into a fall-through FIFO, then checks the CRC16.
module sd_block_reader
   import sd_xfer_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int LEN_W      = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] len,
   input  logic [15:0]      tok_timeout,
   output logic             sh_start_read,
   input  logic             sh_busy,
   input  logic [7:0]       sh_data,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic             err_token,
   output logic             err_crc,
   output sd_state_e        state_dbg
);

   localparam int             AW        = $clog2(FIFO_DEPTH);
   localparam int             CW        = LEN_W + 1;
   localparam logic [CW-1:0]  LEN_MAX   = CW'(512);
   localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

   // Shifter handshake: a one-cycle sh_start_read launches a byte; the shifter
   // is busy from the next cycle and sh_data is valid on the first !sh_busy.
   // FIFO read port: a byte leaves when rd_valid && rd_ready at a clk edge.
   sd_state_e      state_q, state_d;
   logic [15:0]    poll_cnt_q, tok_max_q, tok_lim;
   logic [CW-1:0]  len_q, byte_cnt_q;
   logic [15:0]    crc_q, crc_next;
   logic [7:0]     crc_hi_q;
   logic           crc_idx_q;
   logic           accept, push, pop, flush, tok_poll;
   logic           set_timeout, set_token, crc_hi_load, crc_check;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    cnt_q;
   logic           fifo_full;

   assign tok_lim   = (tok_max_q == 16'd0) ? 16'd1 : tok_max_q;
   assign fifo_full = (cnt_q == DEPTH_CNT);
   assign rd_valid  = (cnt_q != '0);
   assign rd_data   = mem[rd_ptr_q];
   assign pop       = rd_valid && rd_ready;
   assign flush     = abort && (state_q != IDLE);
   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

   crc16_byte u_crc (
      .crc_in    (crc_q),
      .data_byte (sh_data),
      .crc_out   (crc_next)
   );

   always_comb begin
      state_d       = state_q;
      sh_start_read = 1'b0;
      done          = 1'b0;
      accept        = 1'b0;
      push          = 1'b0;
      tok_poll      = 1'b0;
      set_timeout   = 1'b0;
      set_token     = 1'b0;
      crc_hi_load   = 1'b0;
      crc_check     = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start && !sh_busy) begin
               accept  = 1'b1;
               state_d = TOK_ISSUE;
            end
            TOK_ISSUE: begin
               sh_start_read = 1'b1;
               state_d       = TOK_WAIT;
            end
            TOK_WAIT: if (!sh_busy) begin
               if (sh_data == TOKEN_START) begin
                  state_d = DAT_ISSUE;
               end else if (sh_data == IDLE_BYTE) begin
                  tok_poll = 1'b1;
                  if (({1'b0, poll_cnt_q} + 17'd1) >= {1'b0, tok_lim}) begin
                     set_timeout = 1'b1;
                     state_d     = FINISH;
                  end else begin
                     state_d = TOK_ISSUE;
                  end
               end else begin
                  set_token = 1'b1;
                  state_d   = FINISH;
               end
            end
            // Only one byte is ever in flight, so a free slot here guarantees room.
            DAT_ISSUE: if (!fifo_full) begin
               sh_start_read = 1'b1;
               state_d       = DAT_WAIT;
            end
            DAT_WAIT: if (!sh_busy) begin
               push    = 1'b1;
               state_d = ((byte_cnt_q + CW'(1)) == len_q) ? CRC_ISSUE : DAT_ISSUE;
            end
            CRC_ISSUE: begin
               sh_start_read = 1'b1;
               state_d       = CRC_WAIT;
            end
            CRC_WAIT: if (!sh_busy) begin
               if (!crc_idx_q) begin
                  crc_hi_load = 1'b1;
                  state_d     = CRC_ISSUE;
               end else begin
                  crc_check = 1'b1;
                  state_d   = FINISH;
               end
            end
            FINISH: begin
               done    = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         poll_cnt_q  <= '0;
         tok_max_q   <= '0;
         len_q       <= '0;
         byte_cnt_q  <= '0;
         crc_q       <= '0;
         crc_hi_q    <= '0;
         crc_idx_q   <= 1'b0;
         err_timeout <= 1'b0;
         err_token   <= 1'b0;
         err_crc     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            err_timeout <= 1'b0;
            err_token   <= 1'b0;
            err_crc     <= 1'b0;
            tok_max_q   <= tok_timeout;
            len_q       <= (len == '0) ? LEN_MAX : CW'(len);
            poll_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            crc_q       <= '0;
            crc_idx_q   <= 1'b0;
         end
         if (tok_poll)    poll_cnt_q  <= poll_cnt_q + 16'd1;
         if (set_timeout) err_timeout <= 1'b1;
         if (set_token)   err_token   <= 1'b1;
         if (push) begin
            byte_cnt_q <= byte_cnt_q + CW'(1);
            crc_q      <= crc_next;
         end
         if (crc_hi_load) begin
            crc_hi_q  <= sh_data;
            crc_idx_q <= 1'b1;
         end
         if (crc_check && ({crc_hi_q, sh_data} != crc_q)) err_crc <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= sh_data;
   end

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed-plus-random bench for sd_block_reader with a behavioural shifter
// and a reference model of the block-read outcome.
module tb_sd_block_reader;
   import sd_xfer_pkg::*;

   localparam int FIFO_DEPTH = 16;
   localparam int LEN_W      = 10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic [15:0]      tok_timeout = '0;
   logic             sh_start_read;
   logic             sh_busy = 1'b0;
   logic [7:0]       sh_data = 8'h00;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             rd_ready = 1'b0;
   logic             busy, done, err_timeout, err_token, err_crc;
   sd_state_e        state_dbg;

   int n_tests = 0;
   int n_fail = 0;
   int sh_pulses = 0;
   int done_cnt = 0;
   logic [7:0] resp_q[$];
   logic [7:0] exp_q[$];

   sd_block_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
      .tok_timeout(tok_timeout), .sh_start_read(sh_start_read), .sh_busy(sh_busy),
      .sh_data(sh_data), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .done(done), .err_timeout(err_timeout), .err_token(err_token),
      .err_crc(err_crc), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Shifter model: busy for 1..4 cycles after each pulse, then presents the next byte.
   initial begin
      forever begin
         @(negedge clk);
         if (sh_start_read === 1'b1) begin
            sh_pulses++;
            sh_busy = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            sh_data = (resp_q.size() != 0) ? resp_q.pop_front() : 8'hFF;
            sh_busy = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // CRC by long division of the message augmented with 16 zero bits.
   function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
      logic [16:0] rem;
      bit          bt;
      rem = '0;
      for (int i = 0; i < d.size() + 2; i++) begin
         for (int b = 7; b >= 0; b--) begin
            bt  = (i < d.size()) ? d[i][b] : 1'b0;
            rem = {rem[15:0], bt};
            if (rem[16]) rem = rem ^ 17'h11021;
         end
      end
      return rem[15:0];
   endfunction

   task automatic wait_shifter_idle(input string tag);
      int cyc = 0;
      while (sh_busy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 50) check({tag, "_sh_idle"}, 32'(sh_busy), 32'd0);
   endtask

   // mode: 0 random data, 1 i%256, 2 i+1
   task automatic run_xfer(input string tag, input int n_ff, input logic [7:0] tok,
                           input int n_data, input logic [15:0] tmo,
                           input logic [7:0] crc_xor, input int mode, input bit hold);
      logic [7:0]  data[$];
      logic [15:0] crc;
      int          lim, exp_pulses, p0, d0, cyc, budget;
      bit          exp_to, exp_tk, dphase;
      resp_q.delete();
      exp_q.delete();
      lim    = (tmo == 16'd0) ? 1 : int'(tmo);
      exp_to = (n_ff >= lim);
      exp_tk = !exp_to && (tok != 8'hFE);
      dphase = !exp_to && (tok == 8'hFE);
      for (int i = 0; i < n_ff; i++) resp_q.push_back(8'hFF);
      if (!exp_to) resp_q.push_back(tok);
      if (dphase) begin
         for (int i = 0; i < n_data; i++)
            data.push_back(mode == 1 ? 8'(i % 256) : mode == 2 ? 8'(i + 1) : 8'($urandom_range(0, 255)));
         foreach (data[i]) begin
            resp_q.push_back(data[i]);
            exp_q.push_back(data[i]);
         end
         crc = crc_ref(data);
         resp_q.push_back(crc[15:8]);
         resp_q.push_back(crc[7:0] ^ crc_xor);
      end
      exp_pulses = exp_to ? lim : dphase ? n_ff + 1 + n_data + 2 : n_ff + 1;
      budget = n_data * 12 + lim * 8 + 400;
      wait_shifter_idle(tag);
      p0 = sh_pulses;
      d0 = done_cnt;
      @(negedge clk);
      start       = 1'b1;
      len         = (n_data == 512) ? '0 : LEN_W'(n_data);
      tok_timeout = tmo;
      rd_ready    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (hold) begin
         cyc = 0;
         while (sh_pulses < p0 + n_ff + 1 + FIFO_DEPTH && cyc < budget) begin
            @(negedge clk);
            cyc++;
         end
         repeat (30) @(negedge clk);
         check({tag, "_stall_pulses"}, 32'(sh_pulses - p0), 32'(n_ff + 1 + FIFO_DEPTH));
         check({tag, "_stall_valid"}, 32'(rd_valid), 32'd1);
      end
      cyc = 0;
      while (!(done_cnt != d0 && exp_q.size() == 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         rd_ready = ($urandom_range(0, 3) != 0);
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check({tag, "_extra_byte"}, 32'(rd_data), 32'hFFFF_FFFF);
            else check({tag, "_data"}, 32'(rd_data), 32'(exp_q.pop_front()));
         end
      end
      @(negedge clk);
      rd_ready = 1'b0;
      check({tag, "_in_budget"}, 32'(cyc < budget), 32'd1);
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_sh_pulses"}, 32'(sh_pulses - p0), 32'(exp_pulses));
      check({tag, "_errs"}, {29'd0, err_timeout, err_token, err_crc},
            {29'd0, exp_to, exp_tk, dphase && (crc_xor != 8'h00)});
      check({tag, "_fifo_empty"}, 32'(rd_valid), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic run_cut(input string tag, input bit use_reset);
      logic [7:0] data[$];
      logic [15:0] crc;
      int p0, d0, p1, cyc;
      resp_q.delete();
      exp_q.delete();
      resp_q.push_back(8'hFE);
      for (int i = 0; i < 16; i++) data.push_back(8'($urandom_range(0, 255)));
      foreach (data[i]) resp_q.push_back(data[i]);
      crc = crc_ref(data);
      resp_q.push_back(crc[15:8]);
      resp_q.push_back(crc[7:0]);
      wait_shifter_idle(tag);
      p0 = sh_pulses;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      len = LEN_W'(16);
      tok_timeout = 16'd10;
      rd_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (sh_pulses < p0 + 6 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_reached_data"}, 32'(cyc < 200), 32'd1);
      check({tag, "_prefill"}, 32'(rd_valid), 32'd1);
      if (use_reset) begin
         rst_n = 1'b0;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
      end else begin
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_flushed"}, 32'(rd_valid), 32'd0);
      p1 = sh_pulses;
      repeat (12) @(negedge clk);
      check({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
      check({tag, "_no_pulses"}, 32'(sh_pulses - p1), 32'd0);
      check({tag, "_errs"}, {29'd0, err_timeout, err_token, err_crc}, 32'd0);
      check({tag, "_still_empty"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_errs", {29'd0, err_timeout, err_token, err_crc}, 32'd0);
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_pulse", 32'(sh_start_read), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_xfer("basic", 2, 8'hFE, 4, 16'd100, 8'h00, 2, 1'b0);
      run_xfer("timeout3", 20, 8'hFE, 4, 16'd3, 8'h00, 0, 1'b0);
      run_xfer("token05", 1, 8'h05, 4, 16'd10, 8'h00, 0, 1'b0);
      run_xfer("timeout0", 5, 8'hFE, 4, 16'd0, 8'h00, 0, 1'b0);
      run_xfer("tok_edge", 2, 8'hFE, 3, 16'd3, 8'h00, 0, 1'b0);
      run_xfer("len512", 0, 8'hFE, 512, 16'd5, 8'h00, 1, 1'b1);
      run_xfer("crc_bad", 1, 8'hFE, 8, 16'd5, 8'h01, 0, 1'b0);
      run_xfer("clear_errs", 0, 8'hFE, 5, 16'd5, 8'h00, 0, 1'b0);
      run_cut("abort", 1'b0);
      run_xfer("after_abort", 1, 8'hFE, 20, 16'd5, 8'h00, 0, 1'b0);
      run_cut("reset", 1'b1);
      run_xfer("after_reset", 0, 8'hFE, 20, 16'd5, 8'h00, 0, 1'b0);
      for (int r = 0; r < 6; r++)
         run_xfer("random", $urandom_range(0, 3), 8'hFE, $urandom_range(1, 40),
                  16'd8, 8'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0), 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
